// File: rtl/nco_phase_accum_pkg.sv
// -----------------------------------------------------------------------------
// nco_phase_accum_pkg
// Shared widths, reset tuning word, LFSR constants and update-FSM encoding for
// the NCO phase accumulator slice.
//   FREQ_W      width of the tuning word coming from the frequency PIO
//   ACC_W       phase accumulator width (tuning word zero-extended into LSBs)
//   PH_OUT_W    truncated phase width handed to the sine/cosine LUT
//   FRAC_W      accumulator bits discarded by truncation
//   FREQ_RESET  tuning word in force after reset (matches the PIO reset value)
// -----------------------------------------------------------------------------
package nco_phase_accum_pkg;

  localparam int FREQ_W   = 22;
  localparam int ACC_W    = 32;
  localparam int PH_OUT_W = 14;
  localparam int FRAC_W   = ACC_W - PH_OUT_W;

  localparam logic [FREQ_W-1:0] FREQ_RESET = 22'd593410;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } upd_state_e;

endpackage

// File: rtl/nco_phase_accum_if.sv
// -----------------------------------------------------------------------------
// nco_phase_accum_if
// Bundle between the tuning/sample-timing side and the NCO core.
//   freq_word    tuning word from the PIO, may change on any clock
//   sample_en    one-clock strobe: advance phase by one step
//   phase_clr    zero the accumulator at the next sample_en
//   phase_out    registered truncated phase
//   phase_valid  strobe, phase_out updated this cycle
//   wrap         strobe with phase_valid, accumulator overflowed on that step
//   freq_active  tuning word currently in use
//   upd_pending  new word captured, waiting for a sample boundary
// Modports: master drives the control side, slave is the NCO core.
// -----------------------------------------------------------------------------
interface nco_phase_accum_if;
  import nco_phase_accum_pkg::*;

  logic [FREQ_W-1:0]   freq_word;
  logic                sample_en;
  logic                phase_clr;
  logic [PH_OUT_W-1:0] phase_out;
  logic                phase_valid;
  logic                wrap;
  logic [FREQ_W-1:0]   freq_active;
  logic                upd_pending;

  modport master (
    output freq_word, sample_en, phase_clr,
    input  phase_out, phase_valid, wrap, freq_active, upd_pending
  );

  modport slave (
    input  freq_word, sample_en, phase_clr,
    output phase_out, phase_valid, wrap, freq_active, upd_pending
  );

endinterface

// File: rtl/nco_phase_accum_lfsr16.sv
// -----------------------------------------------------------------------------
// nco_lfsr16
// 16-bit Galois LFSR used as truncation dither. Steps once per enable and
// restarts from LFSR_SEED on reset. Only built when NCO_DITHER_EN is defined,
// which is also the only configuration that instantiates it.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   en       advance one step
//   out      current LFSR state
// -----------------------------------------------------------------------------
`ifdef NCO_DITHER_EN
module nco_lfsr16
  import nco_phase_accum_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (en) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  assign out = lfsr_q;

endmodule
`endif

// File: rtl/nco_phase_accum.sv
// -----------------------------------------------------------------------------
// nco_phase_accum
// NCO phase accumulator. Advances phase by the active tuning word on every
// sample strobe and presents the accumulator MSBs to the mixer LUT two clocks
// after the strobe. New tuning words are adopted only once they have been
// stable for two clocks, and only on a sample boundary, so the LUT never sees
// a half-updated word.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      nco_phase_accum_if.slave (tuning input, strobes, phase output)
// Configuration: define NCO_DITHER_EN to add LFSR dither below the truncation
// point before phase_out is taken; otherwise phase_out is plain truncation.
// -----------------------------------------------------------------------------
module nco_phase_accum
  import nco_phase_accum_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  nco_phase_accum_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Tuning word qualification and update FSM
  // ---------------------------------------------------------------------------
  logic [FREQ_W-1:0] freq_q;
  logic [FREQ_W-1:0] freq_q_d;
  logic [FREQ_W-1:0] freq_next;
  logic [FREQ_W-1:0] freq_active;
  upd_state_e        state;
  upd_state_e        state_nxt;
  logic              load_next;
  logic              commit;
  logic              stable;

  assign stable = (freq_q == freq_q_d);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    load_next = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (stable && (freq_q != freq_active)) begin
          state_nxt = ST_PEND;
          load_next = 1'b1;
        end
      end
      ST_PEND: begin
        // A further change means the PIO was still settling: drop the
        // captured word and let it re-qualify from scratch.
        if (freq_q != freq_next) begin
          state_nxt = ST_IDLE;
        end else if (bus.sample_en) begin
          state_nxt = ST_IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // Input registers reset to FREQ_RESET so the PIO reset value does not look
  // like a new word coming out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_q      <= FREQ_RESET;
      freq_q_d    <= FREQ_RESET;
      freq_next   <= FREQ_RESET;
      freq_active <= FREQ_RESET;
      state       <= ST_IDLE;
    end else begin
      freq_q   <= bus.freq_word;
      freq_q_d <= freq_q;
      state    <= state_nxt;
      if (load_next) freq_next   <= freq_q;
      if (commit)    freq_active <= freq_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc;
  logic             carry_q;
  logic             clr_latch;
  logic [ACC_W:0]   acc_sum;

  // The step taken on the commit strobe still uses the old freq_active; the
  // new word applies from the following strobe.
  assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - FREQ_W){1'b0}}, freq_active};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      carry_q   <= 1'b0;
      clr_latch <= 1'b0;
    end else if (bus.sample_en) begin
      if (bus.phase_clr || clr_latch) begin
        acc       <= '0;
        carry_q   <= 1'b0;
        clr_latch <= 1'b0;
      end else begin
        {carry_q, acc} <= acc_sum;
      end
    end else if (bus.phase_clr) begin
      clr_latch <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Truncation (optionally dithered)
  // ---------------------------------------------------------------------------
  logic [PH_OUT_W-1:0] phase_trunc;

`ifdef NCO_DITHER_EN
  logic [15:0]      dither;
  logic [ACC_W-1:0] acc_dith;
  logic [FRAC_W-1:0] frac_unused;

  nco_lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.sample_en),
    .out     (dither)
  );

  // Dither only perturbs the copy sent to the LUT; acc itself is untouched.
  assign acc_dith                   = acc + {{(ACC_W - 16){1'b0}}, dither};
  assign {phase_trunc, frac_unused} = acc_dith;
`else
  assign phase_trunc = acc[ACC_W-1 -: PH_OUT_W];
`endif

  // ---------------------------------------------------------------------------
  // Output pipeline: strobe -> acc (+1) -> phase_out/phase_valid (+2)
  // ---------------------------------------------------------------------------
  logic                valid_d1;
  logic                phase_valid_q;
  logic                wrap_q;
  logic [PH_OUT_W-1:0] phase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_d1      <= 1'b0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      phase_q       <= '0;
    end else begin
      valid_d1      <= bus.sample_en;
      phase_valid_q <= valid_d1;
      wrap_q        <= valid_d1 & carry_q;
      if (valid_d1) phase_q <= phase_trunc;
    end
  end

  assign bus.phase_out   = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.wrap        = wrap_q;
  assign bus.freq_active = freq_active;
  assign bus.upd_pending = (state == ST_PEND);

endmodule
